// File: rtl/adc_spi_sampler.sv
// rtl/adc_spi_sampler.sv - periodic SPI-mode ADC conversion sequencer and deserialiser
//
// Starts a conversion on an external serial ADC every SAMPLE_PERIOD clocks while
// enabled. Each conversion clocks out LEAD_BITS dummy bits and then ADC_BITS data
// bits, MSB first. The result is presented as a parallel word with a one-cycle strobe.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       1 = run periodic conversions
//   adc_miso     serial data from the ADC
//   adc_cs_n     ADC chip select, active low
//   adc_sclk     ADC serial clock, idles low
//   ADC_reading  last completed conversion result
//   ADC_en       one-cycle strobe, ADC_reading updated this cycle
//   overrun      sticky flag, a scheduled start was dropped while busy
module adc_spi_sampler #(
  parameter int ADC_BITS      = 12,
  parameter int LEAD_BITS     = 2,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [ADC_BITS-1:0] ADC_reading,
  output logic                ADC_en,
  output logic                overrun
);

  localparam int N  = LEAD_BITS + ADC_BITS;
  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD);

  localparam logic [BW-1:0] BIT_LAST   = BW'(N);
  localparam logic [BW-1:0] LEAD_CNT   = BW'(LEAD_BITS);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [TW-1:0]       timer_q;
  logic [DW-1:0]       div_q;
  logic [BW-1:0]       bit_q;
  logic [ADC_BITS-1:0] shreg_q;

  logic start;
  logic phase_done;
  logic sclk_rise;
  logic sclk_fall;
  logic conv_done;

  // div_q times every CLK_DIV-long phase (setup, each sclk half, hold).
  // bit_q counts sclk rising edges issued so far in this conversion.
  always_comb begin
    start      = enable && (timer_q == '0);
    phase_done = (div_q == DIV_LAST);
    sclk_rise  = 1'b0;
    sclk_fall  = 1'b0;
    conv_done  = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETUP;
      end
      SETUP: begin
        if (phase_done) begin
          sclk_rise = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_done) begin
          if (adc_sclk) begin
            sclk_fall = 1'b1;
          end else if (bit_q == BIT_LAST) begin
            // Low half after the last falling edge has elapsed
            state_d = HOLD;
          end else begin
            sclk_rise = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          conv_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q     <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b0;
      ADC_reading <= '0;
      ADC_en      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      ADC_en <= 1'b0;

      if (!enable || timer_q == TIMER_LAST) timer_q <= '0;
      else                                  timer_q <= timer_q + TW'(1);

      // A start while busy is dropped, not queued
      if (start && state_q != IDLE) overrun <= 1'b1;

      if (state_q == IDLE || phase_done) div_q <= '0;
      else                               div_q <= div_q + DW'(1);

      if (state_q == IDLE) bit_q <= '0;

      if (start && state_q == IDLE) adc_cs_n <= 1'b0;

      // Sample miso on the clock that drives sclk high; lead bits are skipped
      if (sclk_rise) begin
        adc_sclk <= 1'b1;
        bit_q    <= bit_q + BW'(1);
        if (bit_q >= LEAD_CNT) shreg_q <= {shreg_q[ADC_BITS-2:0], adc_miso};
      end

      if (sclk_fall) adc_sclk <= 1'b0;

      if (conv_done) begin
        adc_cs_n    <= 1'b1;
        ADC_reading <= shreg_q;
        ADC_en      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb/tb_adc_spi_sampler.sv - scoreboard bench for adc_spi_sampler with a serial ADC model
module tb_adc_spi_sampler;

  localparam int AB = 12;
  localparam int LB = 2;
  localparam int CD = 2;
  localparam int NB = AB + LB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n  [2];
  logic          en     [2];
  logic          miso   [2];
  logic          cs_n   [2];
  logic          sclk   [2];
  logic          adc_en [2];
  logic          ovr    [2];
  logic [AB-1:0] rd     [2];

  adc_spi_sampler #(.ADC_BITS(AB), .LEAD_BITS(LB), .CLK_DIV(CD), .SAMPLE_PERIOD(100)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .enable(en[0]), .adc_miso(miso[0]),
    .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .ADC_reading(rd[0]),
    .ADC_en(adc_en[0]), .overrun(ovr[0])
  );

  adc_spi_sampler #(.ADC_BITS(AB), .LEAD_BITS(LB), .CLK_DIV(CD), .SAMPLE_PERIOD(40)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .enable(en[1]), .adc_miso(miso[1]),
    .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .ADC_reading(rd[1]),
    .ADC_en(adc_en[1]), .overrun(ovr[1])
  );

  logic [AB-1:0] stim0[$];
  logic [AB-1:0] stim1[$];
  logic [AB-1:0] exp0[$];
  logic [AB-1:0] exp1[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Value for the conversion starting now; it is also what the DUT must report
  function automatic logic [AB-1:0] take_stim(int ch);
    logic [AB-1:0] v;
    if (ch == 0) begin
      if (stim0.size() > 0) v = stim0.pop_front();
      else                  v = AB'($urandom);
      exp0.push_back(v);
    end else begin
      if (stim1.size() > 0) v = stim1.pop_front();
      else                  v = AB'($urandom);
      exp1.push_back(v);
    end
    return v;
  endfunction

  function automatic logic [AB-1:0] pop_exp(int ch);
    logic [AB-1:0] v = 'x;
    if (ch == 0) begin
      if (exp0.size() > 0) v = exp0.pop_front();
    end else begin
      if (exp1.size() > 0) v = exp1.pop_front();
    end
    return v;
  endfunction

  // ADC model: first frame bit on cs_n fall, next bit on each sclk fall
  for (genvar i = 0; i < 2; i++) begin : g_adc
    logic [NB-1:0] frame  = '0;
    int            idx    = 0;
    bit            active = 1'b0;
    logic          drv    = 1'b0;
    always @(negedge cs_n[i] or posedge cs_n[i] or negedge sclk[i]) begin
      if (cs_n[i] !== 1'b0) begin
        active = 1'b0;
      end else if (!active) begin
        active = 1'b1;
        frame  = {{LB{1'b0}}, take_stim(i)};
        idx    = 0;
        drv    = frame[NB-1];
      end else begin
        idx++;
        if (idx < NB) drv = frame[NB-1-idx];
      end
    end
    assign miso[i] = drv;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // Wait for a strobe, score its value, and check it lines up with cs_n rising
  task automatic wait_strobe(input int ch, input int budget, input string tag, output int t);
    logic prev_cs;
    t = -1;
    prev_cs = cs_n[ch];
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (adc_en[ch] === 1'b1) begin
        t = cyc;
        break;
      end
      prev_cs = cs_n[ch];
    end
    if (t < 0) begin
      timeout_fail({tag, "_timeout"});
    end else begin
      check({tag, "_value"}, 32'(rd[ch]), 32'(pop_exp(ch)));
      check({tag, "_cs_rise"}, {30'd0, prev_cs, cs_n[ch]}, 32'd1);
      @(negedge clk);
      check({tag, "_one_cycle"}, 32'(adc_en[ch]), 32'd0);
    end
  endtask

  task automatic wait_cs_low(input int ch, input int budget, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cs_n[ch] === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail(tag);
  endtask

  // Count cycles where the interface is not idle
  task automatic quiet(input int ch, input int cycles, output int bad);
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (cs_n[ch] !== 1'b1 || sclk[ch] !== 1'b0 || adc_en[ch] !== 1'b0) bad++;
    end
  endtask

  initial begin
    int low, edges, rises, bad, seen;
    int t0, t1, t2, t3, ta, tb, tc;
    logic prev_s;

    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    en[0]    = 1'b0; en[1]    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cs_n",    32'(cs_n[0]),   32'd1);
    check("rst_sclk",    32'(sclk[0]),   32'd0);
    check("rst_reading", 32'(rd[0]),     32'd0);
    check("rst_adc_en",  32'(adc_en[0]), 32'd0);
    check("rst_overrun", 32'(ovr[0]),    32'd0);

    // Out of reset with enable low: nothing happens
    rst_n[0] = 1'b1;
    quiet(0, 1000, bad);
    check("disabled_quiet", 32'(bad), 32'd0);

    // First conversion: frame timing and value
    stim0.push_back(12'hA5C);
    stim0.push_back(12'h000);
    stim0.push_back(12'hFFF);
    stim0.push_back(12'h801);
    en[0]  = 1'b1;
    low    = 0;
    edges  = 0;
    seen   = 0;
    prev_s = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cs_n[0] === 1'b0) begin
        low++;
        if (sclk[0] !== prev_s) edges++;
        prev_s = sclk[0];
      end else if (low > 0) begin
        seen = 1;
        break;
      end
    end
    if (seen == 0) timeout_fail("conv1_timeout");
    t0 = cyc;
    check("conv1_cs_low",  32'(low),       32'd60);
    check("conv1_edges",   32'(edges),     32'd28);
    check("conv1_strobe",  32'(adc_en[0]), 32'd1);
    check("conv1_value",   32'(rd[0]),     32'(pop_exp(0)));
    @(negedge clk);
    check("conv1_one_cycle", 32'(adc_en[0]), 32'd0);
    check("conv1_overrun",   32'(ovr[0]),    32'd0);

    // Periodic conversions, strobes one sample period apart
    wait_strobe(0, 150, "p000", t1);
    check("period_1", 32'(t1 - t0), 32'd100);
    wait_strobe(0, 150, "pFFF", t2);
    check("period_2", 32'(t2 - t1), 32'd100);
    wait_strobe(0, 150, "p801", t3);
    check("period_3", 32'(t3 - t2), 32'd100);
    check("hold_value", 32'(rd[0]), 32'h801);

    // Enable dropped mid-shift: conversion completes, then silence
    stim0.push_back(12'h3C7);
    wait_cs_low(0, 150, "drop_cs_timeout");
    repeat (10) @(negedge clk);
    en[0] = 1'b0;
    wait_strobe(0, 100, "drop", t1);
    quiet(0, 300, bad);
    check("drop_quiet", 32'(bad), 32'd0);
    check("drop_hold",  32'(rd[0]), 32'h3C7);
    check("drop_overrun", 32'(ovr[0]), 32'd0);

    // Reset during the 5th sclk high phase
    stim0.push_back(12'h5A3);
    stim0.push_back(12'h6B4);
    en[0] = 1'b1;
    wait_cs_low(0, 50, "rst_cs_timeout");
    rises  = 0;
    prev_s = sclk[0];
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (prev_s === 1'b0 && sclk[0] === 1'b1) rises++;
      prev_s = sclk[0];
      if (rises == 5) break;
    end
    check("rst_mid_sclk_high", 32'(sclk[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    check("rst_mid_cs_n",    32'(cs_n[0]),   32'd1);
    check("rst_mid_sclk",    32'(sclk[0]),   32'd0);
    check("rst_mid_reading", 32'(rd[0]),     32'd0);
    check("rst_mid_adc_en",  32'(adc_en[0]), 32'd0);
    exp0.delete();
    repeat (3) @(negedge clk);
    check("rst_mid_no_strobe", 32'(adc_en[0]), 32'd0);
    rst_n[0] = 1'b1;
    wait_strobe(0, 100, "after_rst", t1);
    en[0] = 1'b0;
    quiet(0, 100, bad);
    check("after_rst_quiet", 32'(bad), 32'd0);

    // Sample period shorter than a conversion: every other start dropped
    rst_n[1] = 1'b1;
    stim1.push_back(12'h123);
    stim1.push_back(12'h456);
    stim1.push_back(12'h789);
    en[1] = 1'b1;
    repeat (20) @(negedge clk);
    check("ovr_before_drop", 32'(ovr[1]), 32'd0);
    wait_strobe(1, 100, "ovr1", ta);
    check("ovr_after_drop", 32'(ovr[1]), 32'd1);
    wait_strobe(1, 120, "ovr2", tb);
    check("ovr_period_1", 32'(tb - ta), 32'd80);
    wait_strobe(1, 120, "ovr3", tc);
    check("ovr_period_2", 32'(tc - tb), 32'd80);
    en[1] = 1'b0;
    quiet(1, 100, bad);
    check("ovr_quiet", 32'(bad), 32'd0);
    check("ovr_sticky", 32'(ovr[1]), 32'd1);

    check("sb_empty_0", 32'(exp0.size()), 32'd0);
    check("sb_empty_1", 32'(exp1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
